// File: rtl/axi_burst_traffic_checker.sv
// AXI4 master traffic generator and self-checker: writes NUM_BURSTS INCR bursts
// of a counting pattern, optionally reads them back and counts discrepancies.
module axi_burst_traffic_checker #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           BURST_LEN  = 8,
  parameter int unsigned           NUM_BURSTS = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(1)
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    INIT_AXI_TXN,
  input  logic [1:0]              MODE,
  output logic                    TXN_DONE,
  output logic                    ERROR,
  output logic [15:0]             ERR_COUNT,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]              AWLEN,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [7:0]              ARLEN,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  output logic                    RREADY
);

  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));
  localparam logic [DATA_WIDTH-1:0] BURST_BEATS = DATA_WIDTH'(BURST_LEN);
  localparam logic [7:0]            LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [15:0]           LAST_BURST  = 16'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_DONE
  } state_t;

  state_t                  state, state_nxt;
  logic                    init_q;
  logic [1:0]              mode_q;
  logic [15:0]             burst_cnt;
  logic [7:0]              beat_cnt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   burst_data;
  logic [DATA_WIDTH-1:0]   beat_data;
  logic                    txn_done_q, error_q;
  logic [15:0]             err_count_q;

  logic start, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic last_beat, last_burst, burst_end;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign last_burst = (burst_cnt == LAST_BURST);
  assign beat_data  = burst_data + DATA_WIDTH'(beat_cnt);
  assign start      = INIT_AXI_TXN && !init_q && (state == S_IDLE || state == S_DONE);

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign b_hs  = BVALID && BREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = RVALID && RREADY;

  // A read burst ends on an early RLAST as well as on its final beat.
  assign burst_end = b_hs || (r_hs && (last_beat || RLAST));

  assign AWADDR    = addr_q;
  assign ARADDR    = addr_q;
  assign AWLEN     = LAST_BEAT;
  assign ARLEN     = LAST_BEAT;
  assign WDATA     = beat_data;
  assign WSTRB     = '1;
  assign TXN_DONE  = txn_done_q;
  assign ERROR     = error_q;
  assign ERR_COUNT = err_count_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    WLAST     = 1'b0;
    BREADY    = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = (MODE == 2'd2) ? S_RD_ADDR : S_WR_ADDR;
      end
      S_WR_ADDR: begin
        AWVALID = 1'b1;
        if (aw_hs) state_nxt = S_WR_DATA;
      end
      S_WR_DATA: begin
        WVALID = 1'b1;
        WLAST  = last_beat;
        if (w_hs && last_beat) state_nxt = S_WR_RESP;
      end
      S_WR_RESP: begin
        BREADY = 1'b1;
        if (b_hs) begin
          if (!last_burst)          state_nxt = S_WR_ADDR;
          else if (mode_q == 2'd1)  state_nxt = S_DONE;
          else                      state_nxt = S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        ARVALID = 1'b1;
        if (ar_hs) state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        RREADY = 1'b1;
        if (burst_end) state_nxt = last_burst ? S_DONE : S_RD_ADDR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A single read beat can raise up to three independent errors.
  always_comb begin
    err_inc = 2'd0;
    if (b_hs && BRESP != 2'b00) err_inc = 2'd1;
    if (r_hs)
      err_inc = {1'b0, RRESP != 2'b00} + {1'b0, RDATA != beat_data} + {1'b0, RLAST != last_beat};
    err_sum = {1'b0, err_count_q} + {15'd0, err_inc};
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      init_q      <= 1'b0;
      mode_q      <= '0;
      burst_cnt   <= '0;
      beat_cnt    <= '0;
      addr_q      <= '0;
      burst_data  <= '0;
      txn_done_q  <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      init_q <= INIT_AXI_TXN;
      if (start) begin
        mode_q      <= MODE;
        burst_cnt   <= '0;
        beat_cnt    <= '0;
        addr_q      <= BASE_ADDR;
        burst_data  <= SEED;
        txn_done_q  <= 1'b0;
        error_q     <= 1'b0;
        err_count_q <= '0;
      end else begin
        if (err_inc != 2'd0) begin
          error_q     <= 1'b1;
          err_count_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
        if (w_hs || r_hs)
          beat_cnt <= (last_beat || (r_hs && RLAST)) ? '0 : beat_cnt + 8'd1;
        if (burst_end) begin
          if (last_burst) begin
            burst_cnt  <= '0;
            addr_q     <= BASE_ADDR;
            burst_data <= SEED;
          end else begin
            burst_cnt  <= burst_cnt + 16'd1;
            addr_q     <= addr_q + BURST_BYTES;
            burst_data <= burst_data + BURST_BEATS;
          end
        end
        if (state != S_DONE && state_nxt == S_DONE) txn_done_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_traffic_checker.sv
// Bench for axi_burst_traffic_checker: randomly stalling memory slave with
// fault injection, checked against address/data/error rules computed directly.
module tb_axi_burst_traffic_checker;

  localparam int          BL   = 8;
  localparam int          NB   = 4;
  localparam logic [31:0] BASE = 32'hFFFF_FFC0;
  localparam logic [31:0] SEED = 32'hFFFF_FFF0;

  logic        ACLK = 1'b0;
  logic        ARESET, INIT_AXI_TXN;
  logic [1:0]  MODE;
  logic        TXN_DONE, ERROR;
  logic [15:0] ERR_COUNT;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  axi_burst_traffic_checker #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(BL), .NUM_BURSTS(NB),
    .BASE_ADDR(BASE), .SEED(SEED)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .INIT_AXI_TXN(INIT_AXI_TXN), .MODE(MODE),
    .TXN_DONE(TXN_DONE), .ERROR(ERROR), .ERR_COUNT(ERR_COUNT),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed { logic [31:0] d; logic last; } wbeat_t;
  typedef struct packed { logic [31:0] d; logic [1:0] resp; logic last; } rbeat_t;

  int total = 0;
  int bad   = 0;

  // fault knobs (-1 = off) and stall probability in percent
  int stall_pct, bresp_burst, corrupt_burst, corrupt_beat, rresp_burst, rresp_beat;
  int early_burst, early_beat, nolast_burst;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] aw_log[$], ar_log[$];
  wbeat_t      w_log[$];
  rbeat_t      r_log[$];
  int cyc = 0, last_hs_cyc, done_cyc, viol;
  int wr_k, rd_k, wr_beat, rd_beat, b_cnt, b_at_ar;
  bit b_pend, r_act, ar_seen, prev_done;
  logic [31:0] wr_base, rd_base, p_awaddr, p_araddr, p_wdata;
  bit pv_aw, pv_w, p_wlast, pv_b, pv_ar, pv_r;

  // Memory slave: handshakes of the preceding rising edge are retired at the
  // falling edge, then new READY/VALID values are driven for the next edge.
  initial begin
    logic [31:0] a;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0;
    RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0;
    forever begin
      @(negedge ACLK);
      cyc++;
      if (ARESET) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        pv_aw = 0; pv_w = 0; pv_b = 0; pv_ar = 0; pv_r = 0;
        b_pend = 0; r_act = 0; wr_beat = 0; rd_beat = 0;
      end else begin
        aw_hs = pv_aw && AWREADY;
        w_hs  = pv_w && WREADY;
        b_hs  = BVALID && pv_b;
        ar_hs = pv_ar && ARREADY;
        r_hs  = RVALID && pv_r;
        if (aw_hs) begin aw_log.push_back(p_awaddr); wr_base = p_awaddr; wr_beat = 0; end
        if (w_hs) begin
          w_log.push_back('{p_wdata, p_wlast});
          mem[wr_base + 32'(wr_beat * 4)] = p_wdata;
          wr_beat++;
          if (wr_beat == BL) b_pend = 1;
        end
        if (b_hs) begin b_pend = 0; b_cnt++; wr_k++; last_hs_cyc = cyc; end
        if (ar_hs) begin ar_log.push_back(p_araddr); rd_base = p_araddr; rd_beat = 0; r_act = 1; end
        if (r_hs) begin
          r_log.push_back('{RDATA, RRESP, RLAST});
          last_hs_cyc = cyc;
          rd_beat++;
          if (RLAST || rd_beat == BL) begin r_act = 0; rd_k++; end
        end
        if (pv_aw && !aw_hs && (!AWVALID || AWADDR !== p_awaddr)) viol++;
        if (pv_w && !w_hs && (!WVALID || WDATA !== p_wdata || WLAST !== p_wlast)) viol++;
        if (pv_ar && !ar_hs && (!ARVALID || ARADDR !== p_araddr)) viol++;
        pv_aw = AWVALID; p_awaddr = AWADDR;
        pv_w = WVALID; p_wdata = WDATA; p_wlast = WLAST;
        pv_b = BREADY; pv_ar = ARVALID; p_araddr = ARADDR; pv_r = RREADY;
        if (ARVALID && !ar_seen) begin ar_seen = 1; b_at_ar = b_cnt; end
        if (TXN_DONE && !prev_done && done_cyc < 0) done_cyc = cyc;
        prev_done = TXN_DONE;
        AWREADY = ($urandom_range(99) >= stall_pct);
        WREADY  = ($urandom_range(99) >= stall_pct);
        ARREADY = ($urandom_range(99) >= stall_pct);
        BVALID  = b_pend;
        BRESP   = (wr_k == bresp_burst) ? 2'b10 : 2'b00;
        if (!(RVALID && !r_hs)) begin
          if (r_act && $urandom_range(99) >= stall_pct) begin
            a     = rd_base + 32'(rd_beat * 4);
            RDATA = mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
            if (rd_k == corrupt_burst && rd_beat == corrupt_beat) RDATA = RDATA ^ 32'h0000_0100;
            RRESP = (rd_k == rresp_burst && rd_beat == rresp_beat) ? 2'b10 : 2'b00;
            RLAST = (rd_beat == BL - 1);
            if (rd_k == early_burst && rd_beat == early_beat) RLAST = 1;
            if (rd_k == nolast_burst && rd_beat == BL - 1) RLAST = 0;
            RVALID = 1;
          end else begin
            RVALID = 0;
          end
        end
      end
    end
  end

  task automatic clear_run(input int pct);
    aw_log.delete(); ar_log.delete(); w_log.delete(); r_log.delete();
    wr_k = 0; rd_k = 0; b_cnt = 0; b_at_ar = -1; ar_seen = 0;
    last_hs_cyc = -2; done_cyc = -1; viol = 0; stall_pct = pct;
    bresp_burst = -1; corrupt_burst = -1; corrupt_beat = -1; rresp_burst = -1;
    rresp_beat = -1; early_burst = -1; early_beat = -1; nolast_burst = -1;
  endtask

  task automatic start_run(input logic [1:0] m);
    MODE = m;
    @(negedge ACLK) INIT_AXI_TXN = 1;
    @(negedge ACLK) INIT_AXI_TXN = 0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 4000; i++) begin
      if (TXN_DONE) break;
      @(negedge ACLK);
    end
    @(negedge ACLK);
    total++;
    if (TXN_DONE !== 1'b1) begin
      bad++;
      $display("FAIL %s done_timeout: TXN_DONE=%b required 1", name, TXN_DONE);
    end
  endtask

  // Reference: burst addresses, beat data and error totals derived from the rules.
  task automatic check_run(input string name, input logic [1:0] m);
    bit wr = (m != 2'd2);
    bit rd = (m != 2'd1);
    int e = 0, k = 0, j = 0;
    logic [31:0] exp_d;
    total++;
    if (aw_log.size() != (wr ? NB : 0)) begin bad++; $display("FAIL %s aw_count: got %0d want %0d", name, aw_log.size(), wr ? NB : 0); end
    for (int i = 0; i < aw_log.size(); i++) begin
      total++;
      if (aw_log[i] !== BASE + 32'(i * BL * 4)) begin bad++; $display("FAIL %s awaddr[%0d]: got %h want %h", name, i, aw_log[i], BASE + 32'(i * BL * 4)); end
    end
    total++;
    if (w_log.size() != (wr ? NB * BL : 0)) begin bad++; $display("FAIL %s w_count: got %0d want %0d", name, w_log.size(), wr ? NB * BL : 0); end
    for (int i = 0; i < w_log.size(); i++) begin
      total++;
      if (w_log[i].d !== SEED + 32'(i) || w_log[i].last !== ((i % BL) == BL - 1)) begin
        bad++; $display("FAIL %s wbeat[%0d]: got %h/%b want %h/%b", name, i, w_log[i].d, w_log[i].last, SEED + 32'(i), (i % BL) == BL - 1);
      end
    end
    total++;
    if (ar_log.size() != (rd ? NB : 0)) begin bad++; $display("FAIL %s ar_count: got %0d want %0d", name, ar_log.size(), rd ? NB : 0); end
    for (int i = 0; i < ar_log.size(); i++) begin
      total++;
      if (ar_log[i] !== BASE + 32'(i * BL * 4)) begin bad++; $display("FAIL %s araddr[%0d]: got %h want %h", name, i, ar_log[i], BASE + 32'(i * BL * 4)); end
    end
    if (wr && rd) begin
      total++;
      if (b_at_ar != NB) begin bad++; $display("FAIL %s b_before_ar: got %0d want %0d", name, b_at_ar, NB); end
    end
    if (wr && bresp_burst >= 0 && bresp_burst < NB) e++;
    foreach (r_log[i]) begin
      exp_d = SEED + 32'(k * BL + j);
      e += (r_log[i].resp != 2'b00) + (r_log[i].d !== exp_d) + (r_log[i].last != (j == BL - 1));
      if (r_log[i].last || j == BL - 1) begin k++; j = 0; end
      else j++;
    end
    total++;
    if (k != (rd ? NB : 0)) begin bad++; $display("FAIL %s read_bursts: got %0d want %0d", name, k, rd ? NB : 0); end
    total++;
    if (ERR_COUNT !== 16'(e)) begin bad++; $display("FAIL %s err_count: got %0d want %0d", name, ERR_COUNT, e); end
    total++;
    if (ERROR !== (e != 0)) begin bad++; $display("FAIL %s error: got %b want %b", name, ERROR, e != 0); end
    total++;
    if (done_cyc != last_hs_cyc) begin bad++; $display("FAIL %s done_timing: done at %0d want %0d", name, done_cyc, last_hs_cyc); end
    total++;
    if (viol != 0) begin bad++; $display("FAIL %s valid_stability: got %0d violations want 0", name, viol); end
  endtask

  task automatic test_reset();
    ARESET = 1; INIT_AXI_TXN = 0; MODE = 2'd0;
    clear_run(0);
    repeat (2) @(negedge ACLK);
    total++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, TXN_DONE, ERROR, WLAST, ERR_COUNT, AWADDR, ARADDR, WDATA} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %b %h %h %h %h want all zero",
        {AWVALID, WVALID, BREADY, ARVALID, RREADY, TXN_DONE, ERROR, WLAST}, ERR_COUNT, AWADDR, ARADDR, WDATA);
    end
    total++;
    if (AWLEN !== 8'(BL - 1) || ARLEN !== 8'(BL - 1) || WSTRB !== 4'hF) begin
      bad++; $display("FAIL reset_consts: got len %h/%h strb %h want %h/%h f", AWLEN, ARLEN, WSTRB, 8'(BL - 1), 8'(BL - 1));
    end
    ARESET = 0;
    @(negedge ACLK);
  endtask

  task automatic test_write_read();
    clear_run(0); start_run(2'd0); wait_done("write_read"); check_run("write_read", 2'd0);
  endtask

  task automatic test_stalls();
    clear_run(30); start_run(2'd3); wait_done("stalls"); check_run("stalls", 2'd3);
  endtask

  task automatic test_write_only();
    clear_run(20); start_run(2'd1); wait_done("write_only"); check_run("write_only", 2'd1);
  endtask

  task automatic test_read_only();
    clear_run(20); start_run(2'd2); wait_done("read_only"); check_run("read_only", 2'd2);
  endtask

  task automatic test_corrupt();
    clear_run(10); corrupt_burst = 0; corrupt_beat = 3;
    start_run(2'd0); wait_done("corrupt"); check_run("corrupt", 2'd0);
    total++;
    if (ERR_COUNT !== 16'd1) begin bad++; $display("FAIL corrupt_count: got %0d want 1", ERR_COUNT); end
  endtask

  task automatic test_bresp_early_rlast();
    clear_run(0); bresp_burst = 1; early_burst = 2; early_beat = 5;
    start_run(2'd0); wait_done("bresp_early"); check_run("bresp_early", 2'd0);
    total++;
    if (ERR_COUNT !== 16'd2) begin bad++; $display("FAIL bresp_early_count: got %0d want 2", ERR_COUNT); end
  endtask

  task automatic test_multi_error();
    clear_run(25); corrupt_burst = 3; corrupt_beat = 0; rresp_burst = 3; rresp_beat = 0; nolast_burst = 1;
    start_run(2'd0); wait_done("multi_error"); check_run("multi_error", 2'd0);
    total++;
    if (ERR_COUNT !== 16'd3) begin bad++; $display("FAIL multi_error_count: got %0d want 3", ERR_COUNT); end
  endtask

  task automatic test_init_ignored();
    clear_run(30); start_run(2'd0);
    for (int i = 0; i < 500 && w_log.size() < 10; i++) @(negedge ACLK);
    @(negedge ACLK) INIT_AXI_TXN = 1;
    @(negedge ACLK) INIT_AXI_TXN = 0;
    wait_done("init_ignored"); check_run("init_ignored", 2'd0);
  endtask

  task automatic test_reset_midrun();
    clear_run(30); start_run(2'd0);
    for (int i = 0; i < 500 && !(WVALID && w_log.size() >= 2 * BL + 3); i++) @(negedge ACLK);
    total++;
    if (WVALID !== 1'b1) begin bad++; $display("FAIL midrun_reach_wdata: WVALID=%b required 1", WVALID); end
    #2 ARESET = 1;
    #1;
    total++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, TXN_DONE, ERROR, WLAST, ERR_COUNT, AWADDR, ARADDR, WDATA} !== '0) begin
      bad++; $display("FAIL midrun_async_reset: got %b %h %h %h %h want all zero",
        {AWVALID, WVALID, BREADY, ARVALID, RREADY, TXN_DONE, ERROR, WLAST}, ERR_COUNT, AWADDR, ARADDR, WDATA);
    end
    repeat (3) @(negedge ACLK);
    ARESET = 0;
    @(negedge ACLK);
    clear_run(30); start_run(2'd0); wait_done("after_reset"); check_run("after_reset", 2'd0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_stalls();
    test_write_only();
    test_read_only();
    test_corrupt();
    test_bresp_early_rlast();
    test_multi_error();
    test_init_ignored();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_burst_traffic_checker.md
Name: axi_burst_traffic_checker

Overview:
Parametrised AXI4 master traffic generator and self-checker; successor to the fixed 32-bit, 8-beat, single-burst M00_AXI test master. On an init pulse it issues NUM_BURSTS INCR bursts of BURST_LEN beats with a deterministic pattern, optionally reads them back and compares, and reports done, sticky error and an error count. It sits in the Translator example/BFM designs, driving the DUT slave port under test.

Parameters:
ADDR_WIDTH, 32, AXI address width.
DATA_WIDTH, 32, AXI data width (32/64/128).
BURST_LEN, 8, beats per burst (1..256).
NUM_BURSTS, 1, bursts per transaction set (1..65535).
BASE_ADDR, 0, address of burst 0, aligned to burst size in bytes.
SEED, 1, first data word of the pattern.

Ports:
ACLK  in  1  clock; everything is sampled on the rising edge.
ARESET  in  1  asynchronous, active-high reset.
INIT_AXI_TXN  in  1  start request; acts on a 0->1 transition.
MODE  in  2  0 = write then read-compare; 1 = write only; 2 = read-compare only; 3 = same as 0.
TXN_DONE  out  1  run complete; held until the next start.
ERROR  out  1  sticky error flag; cleared on start.
ERR_COUNT  out  16  saturating count of errors; cleared on start.
AWADDR  out  ADDR_WIDTH  write burst address.
AWLEN  out  8  constant BURST_LEN-1.
AWVALID  out  1  write address valid.
AWREADY  in  1  write address ready.
WDATA  out  DATA_WIDTH  write beat data.
WSTRB  out  DATA_WIDTH/8  all ones.
WLAST  out  1  high on beat BURST_LEN-1.
WVALID  out  1  write data valid.
WREADY  in  1  write data ready.
BRESP  in  2  write response.
BVALID  in  1  write response valid.
BREADY  out  1  write response ready.
ARADDR  out  ADDR_WIDTH  read burst address.
ARLEN  out  8  constant BURST_LEN-1.
ARVALID  out  1  read address valid.
ARREADY  in  1  read address ready.
RDATA  in  DATA_WIDTH  read beat data.
RRESP  in  2  read response.
RLAST  in  1  last read beat.
RVALID  in  1  read data valid.
RREADY  out  1  read data ready.

Behaviour:
- Reset: all VALID/READY outputs, TXN_DONE, ERROR, ERR_COUNT, WLAST and the address/data outputs go to 0; state = IDLE. An in-flight burst is abandoned immediately; the slave must be reset alongside.
- Start: INIT_AXI_TXN sampled 1 at edge N after being sampled 0 at N-1, while in IDLE or DONE. This clears TXN_DONE/ERROR/ERR_COUNT and sets AWVALID (MODE 0/1/3) or ARVALID (MODE 2) from edge N+1. A rising edge while busy is ignored.
- FSM: IDLE -> WR_ADDR -> WR_DATA -> WR_RESP -> (next burst: WR_ADDR | all written: RD_ADDR, or DONE for MODE 1).
- FSM: RD_ADDR -> RD_DATA -> (next burst: RD_ADDR | all read: DONE). DONE -> WR_ADDR/RD_ADDR on a new start.
- One outstanding burst at a time. W starts only after the AW handshake. The next AW is issued only after the B handshake.
- VALID stays high with payload stable until READY. BREADY is high only in WR_RESP; RREADY is high only in RD_DATA.
- Burst k address: BASE_ADDR + k*BURST_LEN*(DATA_WIDTH/8), modulo 2^ADDR_WIDTH.
- Beat j of burst k data: (SEED + k*BURST_LEN + j) mod 2^DATA_WIDTH.
- Errors: each of these increments ERR_COUNT (saturating at 0xFFFF) and sets ERROR:
  - BRESP != 0;
  - RRESP != 0;
  - RDATA != expected, once per beat even if RRESP is also bad, so such a beat counts 2;
  - RLAST high before beat BURST_LEN-1, where the burst ends at that beat;
  - RLAST low on beat BURST_LEN-1, where the burst still ends after BURST_LEN beats.
- TXN_DONE rises the cycle after the final B handshake (MODE 1) or the final R beat.

Test Plan:
- Defaults, MODE 0, memory slave -> AWADDR 0x0, WDATA 1..8, WLAST on beat 8, readback matches, TXN_DONE=1, ERROR=0, ERR_COUNT=0.
- BURST_LEN 16, NUM_BURSTS 4, DATA_WIDTH 32 -> AWADDR 0x00/0x40/0x80/0xC0; all 4 B handshakes complete before the first ARVALID.
- Slave corrupts read beat 3 of burst 0 -> ERROR=1, ERR_COUNT=1, TXN_DONE=1 after all bursts.
- BRESP=2'b10 on burst 1 and RLAST on beat 6 of 8 -> ERR_COUNT=2; the next ARVALID follows that beat.
- Random 30% AWREADY/WREADY/ARREADY/RVALID stalls -> same results as the first scenario; no VALID drops or payload change without a handshake.
- INIT pulse mid-run ignored; ARESET during WR_DATA -> all outputs 0 asynchronously; next INIT restarts from burst 0 at BASE_ADDR.
